// File: rtl/slope_sync_ctrl.sv
// Qualifies slope-detector flags into edge events, measures the rising-edge period and tracks lock.
// Optional feature macro: SLOPE_SYNC_TIMEOUT_EN (drop lock when no rising edge arrives within 2x the last period).
module slope_sync_ctrl #(
  parameter int CNT_W    = 16,
  parameter int QUAL_LEN = 3,
  parameter int HOLDOFF  = 32,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_pos_slope,
  input  logic             i_neg_slope,
  output logic             o_edge_pos,
  output logic             o_edge_neg,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_vld,
  output logic             o_locked,
  output logic             o_sync_pulse,
  output logic             o_lock_lost
);

  localparam int QW = $clog2(QUAL_LEN + 1);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int XW = CNT_W + 1;

  localparam logic [QW-1:0]    QUAL_LAST = QW'(QUAL_LEN - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLDOFF - 1);
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [XW-1:0]    TOL_X     = XW'(TOL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HUNT = 2'd1,
    S_QUAL = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           state_r;
  logic             dir_r;
  logic [QW-1:0]    qcnt_r;
  logic [HW-1:0]    hcnt_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] prev_r;
  logic             prev_vld_r;
  logic             have_ref_r;
  logic [MW-1:0]    match_r;
  logic             lock_lost_r;

  logic             flag_sel_s;
  logic             flag_opp_s;
  logic             one_hot_s;
  logic             fire_s;
  logic             fire_neg_s;
  logic             fire_pos_s;
  logic             cnt_sat_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [XW-1:0]    diff_s;
  logic             in_tol_s;
  logic [MW-1:0]    match_next_s;

  // dir_r=1 means the qualification run is tracking the falling-slope flag
  assign flag_sel_s   = dir_r ? i_neg_slope : i_pos_slope;
  assign flag_opp_s   = dir_r ? i_pos_slope : i_neg_slope;
  assign one_hot_s    = i_pos_slope ^ i_neg_slope;
  assign fire_pos_s   = fire_s & ~fire_neg_s;
  assign cnt_sat_s    = (cnt_r == CNT_MAX);
  assign cnt_next_s   = cnt_sat_s ? cnt_r : cnt_r + CNT_ONE;
  assign diff_s       = ({1'b0, cnt_r} >= {1'b0, prev_r}) ? ({1'b0, cnt_r} - {1'b0, prev_r})
                                                          : ({1'b0, prev_r} - {1'b0, cnt_r});
  assign in_tol_s     = prev_vld_r && (diff_s <= TOL_X);
  assign match_next_s = (match_r == MATCH_MAX) ? MATCH_MAX : match_r + MW'(1);
  assign o_sync_pulse = o_edge_pos & o_locked;
  assign o_lock_lost  = lock_lost_r;

`ifdef SLOPE_SYNC_TIMEOUT_EN
  logic timeout_s;
  assign timeout_s = o_locked && prev_vld_r && ({1'b0, cnt_r} > {prev_r, 1'b0});
`endif

  // Edge qualification decision for the current sample
  always_comb begin
    fire_s     = 1'b0;
    fire_neg_s = 1'b0;
    case (state_r)
      S_HUNT: begin
        if (one_hot_s && (QUAL_LEN == 1)) begin
          fire_s     = 1'b1;
          fire_neg_s = i_neg_slope;
        end else begin
          fire_s     = 1'b0;
          fire_neg_s = 1'b0;
        end
      end
      S_QUAL: begin
        if (flag_sel_s && !flag_opp_s && (qcnt_r == QUAL_LAST)) begin
          fire_s     = 1'b1;
          fire_neg_s = dir_r;
        end else begin
          fire_s     = 1'b0;
          fire_neg_s = 1'b0;
        end
      end
      default: begin
        fire_s     = 1'b0;
        fire_neg_s = 1'b0;
      end
    endcase
  end

  // Qualification FSM, period measurement and lock tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      dir_r        <= 1'b0;
      qcnt_r       <= {QW{1'b0}};
      hcnt_r       <= {HW{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      prev_r       <= {CNT_W{1'b0}};
      prev_vld_r   <= 1'b0;
      have_ref_r   <= 1'b0;
      match_r      <= {MW{1'b0}};
      lock_lost_r  <= 1'b0;
      o_edge_pos   <= 1'b0;
      o_edge_neg   <= 1'b0;
      o_period     <= {CNT_W{1'b0}};
      o_period_vld <= 1'b0;
      o_locked     <= 1'b0;
    end else if (!i_en) begin
      // o_period deliberately holds across a disable
      state_r      <= S_IDLE;
      prev_vld_r   <= 1'b0;
      have_ref_r   <= 1'b0;
      match_r      <= {MW{1'b0}};
      lock_lost_r  <= 1'b0;
      o_edge_pos   <= 1'b0;
      o_edge_neg   <= 1'b0;
      o_period_vld <= 1'b0;
      o_locked     <= 1'b0;
    end else begin
      o_edge_pos   <= fire_pos_s;
      o_edge_neg   <= fire_s & fire_neg_s;
      o_period_vld <= 1'b0;
      lock_lost_r  <= 1'b0;
      cnt_r        <= cnt_next_s;

      case (state_r)
        S_IDLE: state_r <= S_HUNT;
        S_HUNT: begin
          if (fire_s) begin
            state_r <= S_HOLD;
            hcnt_r  <= {HW{1'b0}};
          end else if (one_hot_s) begin
            state_r <= S_QUAL;
            dir_r   <= i_neg_slope;
            qcnt_r  <= QW'(1);
          end else begin
            state_r <= S_HUNT;
          end
        end
        S_QUAL: begin
          if (fire_s) begin
            state_r <= S_HOLD;
            hcnt_r  <= {HW{1'b0}};
          end else if (flag_sel_s && !flag_opp_s) begin
            qcnt_r  <= qcnt_r + QW'(1);
          end else begin
            state_r <= S_HUNT;
          end
        end
        S_HOLD: begin
          if (hcnt_r == HOLD_LAST) begin
            state_r <= S_HUNT;
          end else begin
            hcnt_r  <= hcnt_r + HW'(1);
          end
        end
        default: state_r <= S_IDLE;
      endcase

      if (fire_pos_s) begin
        cnt_r <= CNT_ONE;
        if (!have_ref_r) begin
          have_ref_r <= 1'b1;
        end else if (cnt_sat_s) begin
          // Overflowed interval is not a usable period
          match_r    <= {MW{1'b0}};
          o_locked   <= 1'b0;
          prev_vld_r <= 1'b0;
        end else begin
          o_period     <= cnt_r;
          o_period_vld <= 1'b1;
          prev_r       <= cnt_r;
          prev_vld_r   <= 1'b1;
          if (in_tol_s) begin
            match_r  <= match_next_s;
            o_locked <= (match_next_s == MATCH_MAX);
          end else begin
            match_r  <= {MW{1'b0}};
            o_locked <= 1'b0;
          end
        end
      end
`ifdef SLOPE_SYNC_TIMEOUT_EN
      else if (timeout_s) begin
        o_locked    <= 1'b0;
        match_r     <= {MW{1'b0}};
        prev_vld_r  <= 1'b0;
        lock_lost_r <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_slope_sync_ctrl.sv
// Directed bench for slope_sync_ctrl with hand-computed expectations.
// Covers both builds of SLOPE_SYNC_TIMEOUT_EN.
module tb_slope_sync_ctrl;

  logic        clk;
  logic        reset;
  logic        en_s;
  logic        pos_s;
  logic        neg_s;
  logic        o_edge_pos;
  logic        o_edge_neg;
  logic [15:0] o_period;
  logic        o_period_vld;
  logic        o_locked;
  logic        o_sync_pulse;
  logic        o_lock_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int pos_edges = 0;
  int neg_edges = 0;
  int sync_cnt  = 0;
  int lost_cnt  = 0;

  logic        e_edge;
  logic        e_vld;
  logic        e_lk;
  logic        e_sp;
  logic [15:0] e_per;
  int          mark;
  int          found;

  slope_sync_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .i_en         (en_s),
    .i_pos_slope  (pos_s),
    .i_neg_slope  (neg_s),
    .o_edge_pos   (o_edge_pos),
    .o_edge_neg   (o_edge_neg),
    .o_period     (o_period),
    .o_period_vld (o_period_vld),
    .o_locked     (o_locked),
    .o_sync_pulse (o_sync_pulse),
    .o_lock_lost  (o_lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic p, input logic n);
    pos_s = p;
    neg_s = n;
    @(posedge clk);
    #1;
    if (o_edge_pos)   pos_edges++;
    if (o_edge_neg)   neg_edges++;
    if (o_sync_pulse) sync_cnt++;
    if (o_lock_lost)  lost_cnt++;
  endtask

  // gap low samples minus 3, then 3 high samples; the edge pulse lands after the last one
  task automatic pos_burst(input int gap);
    repeat (gap - 3) tick(1'b0, 1'b0);
    repeat (3) tick(1'b1, 1'b0);
    e_edge = o_edge_pos;
    e_vld  = o_period_vld;
    e_lk   = o_locked;
    e_sp   = o_sync_pulse;
    e_per  = o_period;
  endtask

  initial begin
    reset = 1'b1;
    en_s  = 1'b0;
    pos_s = 1'b0;
    neg_s = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    check_eq("rst_edge_pos", 32'(o_edge_pos), 0);
    check_eq("rst_period", 32'(o_period), 0);
    check_eq("rst_locked", 32'(o_locked), 0);
    check_eq("rst_misc", 32'({o_edge_neg, o_period_vld, o_sync_pulse, o_lock_lost}), 0);

    reset = 1'b0;
    en_s  = 1'b1;
    repeat (4) tick(1'b0, 1'b0);

    // Test 1: steady 200-cycle bursts, lock on edge 6
    pos_burst(10);
    check_eq("t1_e1_edge", 32'(e_edge), 1);
    check_eq("t1_e1_vld", 32'(e_vld), 0);
    check_eq("t1_e1_lock", 32'(e_lk), 0);
    for (int k = 2; k <= 7; k++) begin
      pos_burst(200);
      check_eq("t1_edge", 32'(e_edge), 1);
      check_eq("t1_vld", 32'(e_vld), 1);
      check_eq("t1_period", 32'(e_per), 200);
      check_eq("t1_locked", 32'(e_lk), (k >= 6) ? 1 : 0);
      check_eq("t1_sync", 32'(e_sp), (k >= 6) ? 1 : 0);
    end
    check_eq("t1_pos_count", 32'(pos_edges), 7);
    check_eq("t1_sync_count", 32'(sync_cnt), 2);

    // Test 4: in-tolerance jitter keeps lock, a large step breaks it
    pos_burst(205);
    check_eq("t4_205_lock", 32'(e_lk), 1);
    check_eq("t4_205_period", 32'(e_per), 205);
    pos_burst(198);
    check_eq("t4_198_lock", 32'(e_lk), 1);
    check_eq("t4_198_sync", 32'(e_sp), 1);
    pos_burst(230);
    check_eq("t4_230_edge", 32'(e_edge), 1);
    check_eq("t4_230_lock", 32'(e_lk), 0);
    check_eq("t4_230_sync", 32'(e_sp), 0);
    check_eq("t4_230_period", 32'(e_per), 230);
    check_eq("t4_230_vld", 32'(e_vld), 1);
    check_eq("t4_sync_count", 32'(sync_cnt), 4);

    // Test 2: short positive run is rejected, negative run qualifies
    repeat (50) tick(1'b0, 1'b0);
    mark = pos_edges;
    repeat (2) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b1);
    check_eq("t2_neg_edge", 32'(o_edge_neg), 1);
    check_eq("t2_no_vld", 32'(o_period_vld), 0);
    check_eq("t2_period_kept", 32'(o_period), 230);
    repeat (50) tick(1'b0, 1'b0);
    check_eq("t2_no_pos", 32'(pos_edges), 32'(mark));
    check_eq("t2_neg_count", 32'(neg_edges), 1);

    // Both flags together never qualify
    repeat (5) tick(1'b1, 1'b1);
    repeat (5) tick(1'b0, 1'b0);
    check_eq("t5_both_pos", 32'(pos_edges), 32'(mark));
    check_eq("t5_both_neg", 32'(neg_edges), 1);

    // Test 3: re-trigger inside holdoff is blanked, after holdoff it fires
    repeat (3) tick(1'b1, 1'b0);
    check_eq("t3_first_edge", 32'(o_edge_pos), 1);
    mark = pos_edges;
    repeat (7) tick(1'b0, 1'b0);
    repeat (3) tick(1'b1, 1'b0);
    repeat (27) tick(1'b0, 1'b0);
    check_eq("t3_blanked", 32'(pos_edges), 32'(mark));
    repeat (3) tick(1'b1, 1'b0);
    check_eq("t3_second_edge", 32'(o_edge_pos), 1);
    check_eq("t3_period", 32'(o_period), 40);
    check_eq("t3_vld", 32'(o_period_vld), 1);
    tick(1'b0, 1'b0);
    check_eq("t3_pulse_width", 32'({o_edge_pos, o_period_vld}), 0);

    // Test 5: relock, then drop enable in the middle of qualification
    for (int k = 1; k <= 5; k++) begin
      pos_burst(200);
      check_eq("t5_lock_seq", 32'(e_lk), (k == 5) ? 1 : 0);
    end
    repeat (100) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    en_s = 1'b0;
    tick(1'b1, 1'b0);
    check_eq("t5_dis_locked", 32'(o_locked), 0);
    check_eq("t5_dis_pulses", 32'({o_edge_pos, o_edge_neg, o_sync_pulse, o_period_vld}), 0);
    check_eq("t5_dis_period", 32'(o_period), 200);
    repeat (3) tick(1'b0, 1'b0);
    en_s = 1'b1;
    pos_burst(10);
    check_eq("t5_reen_edge", 32'(e_edge), 1);
    check_eq("t5_reen_vld", 32'(e_vld), 0);
    for (int k = 1; k <= 5; k++) begin
      pos_burst(200);
      check_eq("t5_relock_vld", 32'(e_vld), 1);
      check_eq("t5_relock", 32'(e_lk), (k == 5) ? 1 : 0);
    end

    // Test 6: rising edges stop while locked
`ifdef SLOPE_SYNC_TIMEOUT_EN
    found = -1;
    for (int k = 1; k <= 1000; k++) begin
      tick(1'b0, 1'b0);
      if (o_lock_lost) begin
        found = k;
        break;
      end
    end
    check_eq("t6_lost_delay", 32'(found), 401);
    check_eq("t6_lost_unlocked", 32'(o_locked), 0);
    repeat (20) tick(1'b0, 1'b0);
    check_eq("t6_lost_once", 32'(lost_cnt), 1);
    pos_burst(100);
    check_eq("t6_after_vld", 32'(e_vld), 1);
    check_eq("t6_after_period", 32'(e_per), 521);
    check_eq("t6_after_lock", 32'(e_lk), 0);
`else
    repeat (1000) tick(1'b0, 1'b0);
    check_eq("t6_still_locked", 32'(o_locked), 1);
    check_eq("t6_no_lost", 32'(lost_cnt), 0);
    pos_burst(66000);
    check_eq("t6_sat_edge", 32'(e_edge), 1);
    check_eq("t6_sat_vld", 32'(e_vld), 0);
    check_eq("t6_sat_lock", 32'(e_lk), 0);
    check_eq("t6_sat_sync", 32'(e_sp), 0);
    check_eq("t6_sat_period", 32'(e_per), 200);
    pos_burst(200);
    check_eq("t6_post_vld", 32'(e_vld), 1);
    check_eq("t6_post_period", 32'(e_per), 200);
    check_eq("t6_post_lock", 32'(e_lk), 0);
`endif

    // Reset mid-operation also clears the period
    reset = 1'b1;
    tick(1'b0, 1'b0);
    check_eq("mid_rst_period", 32'(o_period), 0);
    check_eq("mid_rst_locked", 32'(o_locked), 0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
